// File: rtl/uart_pkg.sv
// uart_pkg: constants and FSM encoding shared by the UART receive path
// and, later, the transmit path (freq38K/uart_tx).
//   DATA_BITS     payload bits per 8N1 frame
//   OVERSAMPLE    oversample ticks per bit (receiver counters assume 16)
//   MID_LO/MID/MID_HI  sample counts used for the majority vote
//   S_*           receiver FSM state encoding (3 bits)
//   calc_div()    clocks per oversample tick for a given clock and baud
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int MID_LO     = 7;
  localparam int MID        = 8;
  localparam int MID_HI     = 9;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  // Integer division: the tick rate ends up slightly fast of the true
  // baud, which the mid-bit sampling easily absorbs over one frame.
  function automatic int calc_div(input int clk_freq, input int baud,
                                  input int os = OVERSAMPLE);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: free-running divider producing one oversample tick.
//   clock  in   system clock, rising edge
//   reset  in   asynchronous active-low reset (counter -> 0)
//   tick   out  high for one clock when the count reaches DIV-1
module baud_tick_gen #(
  parameter int DIV = 82
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));
  assign tick   = w_wrap;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_sys.sv
// uart_rx_sys: 8N1 UART receiver with 16x oversampling, 2-flop input
// synchronizer, 3-sample majority vote, framing/overrun detection and a
// valid/ack output handshake.
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   rxPin      in   asynchronous serial line, idles high
//   rx_ack     in   consumer takes rx_data while rx_valid=1
//   rx_data    out  last accepted byte (LSB first on the line)
//   rx_valid   out  rx_data holds an unconsumed byte
//   frame_err  out  one-clock pulse when the stop bit samples 0
//   overrun    out  sticky: a completed byte was dropped
//   busy       out  FSM is not idle
module uart_rx_sys
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 38000,
  parameter int OVERSAMPLE = 16,
  parameter int DIV        = calc_div(CLK_FREQ, BAUD, OVERSAMPLE)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rxPin,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  logic                 r_sync1, r_sync2, r_sync_d;
  logic                 w_tick;
  logic [2:0]           r_state;
  logic [3:0]           r_samp_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_s_lo, r_s_mid;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid, r_frame_err, r_overrun;

  logic w_fall, w_vote, w_at_hi, w_at_last;
  logic w_stop_ok, w_load, w_ovr_set, w_consume, w_stop_bad;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (w_tick)
  );

  // Falling edge seen on the synchronized line (one extra flop of history).
  assign w_fall    = r_sync_d & ~r_sync2;
  // Count-9 sample is taken live; counts 7 and 8 were captured earlier.
  assign w_vote    = (r_s_lo & r_s_mid) | (r_s_lo & r_sync2) | (r_s_mid & r_sync2);
  assign w_at_hi   = w_tick && (r_samp_cnt == 4'(MID_HI));
  assign w_at_last = w_tick && (r_samp_cnt == 4'(OVERSAMPLE - 1));

  assign w_stop_ok  = (r_state == S_STOP) && w_at_hi && w_vote;
  assign w_stop_bad = (r_state == S_STOP) && w_at_hi && !w_vote;
  // An ack on the completion clock frees the holding register in time.
  assign w_load     = w_stop_ok && (!r_rx_valid || rx_ack);
  assign w_ovr_set  = w_stop_ok && r_rx_valid && !rx_ack;
  assign w_consume  = r_rx_valid && rx_ack;

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != S_IDLE);

  // Synchronizer resets high so releasing reset never looks like a start edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync1  <= rxPin;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_samp_cnt <= '0;
      r_s_lo     <= 1'b1;
      r_s_mid    <= 1'b1;
    end else begin
      if ((r_state == S_IDLE) && w_fall) begin
        r_samp_cnt <= '0;
      end else if (w_tick) begin
        r_samp_cnt <= r_samp_cnt + 4'd1;
      end
      if (w_tick && (r_samp_cnt == 4'(MID_LO))) r_s_lo  <= r_sync2;
      if (w_tick && (r_samp_cnt == 4'(MID)))    r_s_mid <= r_sync2;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall) r_state <= S_START;
        end
        S_START: begin
          // A start bit that votes high was noise; drop it silently.
          if (w_at_hi && w_vote) begin
            r_state <= S_IDLE;
          end else if (w_at_last) begin
            r_state   <= S_DATA;
            r_bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (w_at_hi) r_shift[r_bit_idx] <= w_vote;
          if (w_at_last) begin
            if (r_bit_idx == 3'(DATA_BITS - 1)) r_state <= S_STOP;
            else                                r_bit_idx <= r_bit_idx + 3'd1;
          end
        end
        S_STOP: begin
          if (w_at_hi) r_state <= w_vote ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          // Wait out a held-low line so it reports only one framing error.
          if (r_sync2) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (w_consume) begin
        r_rx_valid <= 1'b0;
      end
      r_frame_err <= w_stop_bad;
      if (w_ovr_set)      r_overrun <= 1'b1;
      else if (w_consume) r_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_sys.sv
`timescale 1ns/1ps
module tb_uart_rx_sys;

  // Clock scaled so DIV = 8 (4.864 MHz / (38000*16)); one bit = 128 clocks.
  localparam int CLK_FREQ = 4864000;
  localparam int TICK     = 8;
  localparam int BIT      = 16 * TICK;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rxPin = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  int checks = 0;
  int errors = 0;
  int ferr_seen = 0;

  uart_rx_sys #(.CLK_FREQ(CLK_FREQ), .BAUD(38000)) dut (
    .clock     (clock),
    .reset     (reset),
    .rxPin     (rxPin),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #10 clock = ~clock;

  always @(negedge clock) if (frame_err === 1'b1) ferr_seen++;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] data;
    logic       stop_v;
    bit         ack;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ovr;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rxPin = v;
    repeat (n) @(negedge clock);
  endtask

  // One frame: start, 8 data bits LSB first, stop; optional inverted spike.
  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input int spike_bit, input int spike_off, input int spike_len);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < BIT; c++) begin
        if (i == spike_bit && c >= spike_off && c < spike_off + spike_len) rxPin = ~b[i];
        else rxPin = b[i];
        @(negedge clock);
      end
    end
    hold(stop_v, BIT);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_v);
    send_frame(b, stop_v, -1, 0, 0);
    hold(1'b1, BIT);
    $display("frame 0x%02h stop=%0b -> rx_data=0x%02h valid=%0b overrun=%0b", b, stop_v,
             rx_data, rx_valid, overrun);
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    @(negedge clock);
    rx_ack = 1'b0;
    @(negedge clock);
  endtask

  task automatic ack_check(input string name);
    do_ack();
    check({name, "_valid_clr"}, rx_valid, 0);
    check({name, "_ovr_clr"}, overrun, 0);
  endtask

  logic [7:0] m_data;
  logic       m_valid, m_ovr;
  int         m_ferr, f0, n;
  logic [7:0] rb;
  logic       rs;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 0};
    vecs[2] = '{8'h81, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 0};
    vecs[3] = '{8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 0};
    vecs[4] = '{8'h5A, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 1};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 0};

    repeat (5) @(negedge clock);
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    hold(1'b1, 2 * BIT);
    check("idle_busy", busy, 0);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      f0 = ferr_seen;
      send(vecs[v].data, vecs[v].stop_v);
      check($sformatf("vec%0d_data", v), rx_data, vecs[v].exp_data);
      check($sformatf("vec%0d_valid", v), rx_valid, vecs[v].exp_valid);
      check($sformatf("vec%0d_ovr", v), overrun, vecs[v].exp_ovr);
      check($sformatf("vec%0d_ferr", v), ferr_seen - f0, vecs[v].exp_ferr);
      if (vecs[v].ack) ack_check($sformatf("vec%0d_ack", v));
    end

    // Bad stop bit followed by a long break: one frame_err only
    f0 = ferr_seen;
    send_frame(8'h55, 1'b0, -1, 0, 0);
    hold(1'b0, 2 * BIT);
    check("break_busy", busy, 1);
    hold(1'b0, 3 * BIT);
    hold(1'b1, 2 * BIT);
    check("break_ferr_once", ferr_seen - f0, 1);
    check("break_valid", rx_valid, 0);
    check("break_busy_clr", busy, 0);
    send(8'h0F, 1'b1);
    check("after_break_data", rx_data, 8'h0F);
    check("after_break_valid", rx_valid, 1);
    ack_check("after_break_ack");

    // Start-bit glitch of 4 tick periods
    f0 = ferr_seen;
    hold(1'b0, 4 * TICK);
    check("glitch_busy", busy, 1);
    rxPin = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < BIT) begin
      @(negedge clock);
      n++;
    end
    check("glitch_busy_clr", busy, 0);
    hold(1'b1, BIT);
    check("glitch_valid", rx_valid, 0);
    check("glitch_ferr", ferr_seen - f0, 0);
    $display("glitch released busy after %0d clocks", n);

    // Short spike near mid-bit of bit 3 must be voted out
    send_frame(8'h00, 1'b1, 3, 66, 5);
    hold(1'b1, BIT);
    check("spike_data", rx_data, 8'h00);
    check("spike_valid", rx_valid, 1);
    ack_check("spike_ack");

    // Leave a byte pending, then reset during bit 4 of 0xFF
    send(8'h7E, 1'b1);
    check("prerst_data", rx_data, 8'h7E);
    hold(1'b0, BIT);
    hold(1'b1, 4 * BIT + BIT / 2);
    reset = 1'b0;
    hold(1'b1, 5);
    check("inrst_busy", busy, 0);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_data", rx_data, 0);
    check("midrst_valid", rx_valid, 0);
    check("midrst_ferr", frame_err, 0);
    check("midrst_ovr", overrun, 0);
    check("midrst_busy", busy, 0);
    f0 = ferr_seen;
    hold(1'b1, 5 * BIT);
    send(8'h12, 1'b1);
    check("postrst_data", rx_data, 8'h12);
    check("postrst_valid", rx_valid, 1);
    check("postrst_ovr", overrun, 0);
    check("postrst_ferr", ferr_seen - f0, 0);
    do_ack();

    // Randomized frames against a byte-level model of the handshake
    m_data = 8'h12; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 0;
    f0 = ferr_seen;
    for (int k = 0; k < 10; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 5) != 0);
      send(rb, rs);
      if (!rs) m_ferr++;
      else if (!m_valid) begin m_data = rb; m_valid = 1'b1; end
      else m_ovr = 1'b1;
      check($sformatf("rnd%0d_data", k), rx_data, m_data);
      check($sformatf("rnd%0d_valid", k), rx_valid, m_valid);
      check($sformatf("rnd%0d_ovr", k), overrun, m_ovr);
      check($sformatf("rnd%0d_ferr", k), ferr_seen - f0, m_ferr);
      if ($urandom_range(0, 1) == 1) begin
        do_ack();
        if (m_valid) begin m_valid = 1'b0; m_ovr = 1'b0; end
        check($sformatf("rnd%0d_ack_valid", k), rx_valid, m_valid);
        check($sformatf("rnd%0d_ack_ovr", k), overrun, m_ovr);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
